// File: rtl/alu_pkg.sv
// alu_pkg: shared RV32I encodings, bundle layout and stage state for the ALU operand stage
package alu_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_SRLSRA = 3'b101;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;
    typedef enum logic {EMPTY, FULL} bundleState_t;
    typedef struct packed {
        logic [XLEN-1:0] dataA;
        logic [XLEN-1:0] dataB;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic            illegal;
    } bundle_t;
endpackage

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, two async read ports, one sync write port, x0 reads zero
module reg_file
    import alu_pkg::*;
(
    input  logic            iClk,
    input  logic            iRstN,
    input  logic            iWe,
    input  logic [4:0]      iWAddr,
    input  logic [XLEN-1:0] iWData,
    input  logic [4:0]      iRAddrA,
    output logic [XLEN-1:0] oRDataA,
    input  logic [4:0]      iRAddrB,
    output logic [XLEN-1:0] oRDataB
);
    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (iWe && iWAddr != '0) begin
            mem[iWAddr] <= iWData;
        end
    end

    assign oRDataA = (iRAddrA == '0) ? '0 : mem[iRAddrA];
    assign oRDataB = (iRAddrB == '0) ? '0 : mem[iRAddrB];
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decodes RV32I ALU instructions, fetches operands and holds a registered bundle for the ALU
module alu_operand_stage
    import alu_pkg::*;
(
    input  logic            iClk,
    input  logic            iRstN,
    input  logic            iInstrValid,
    input  logic [31:0]     iInstr,
    output logic            oInstrReady,
    output logic            oOpValid,
    input  logic            iOpReady,
    output logic [XLEN-1:0] oDataA,
    output logic [XLEN-1:0] oDataB,
    output logic [2:0]      oFunct3,
    output logic [6:0]      oFunct7,
    output logic [4:0]      oRd,
    output logic            oIllegal,
    input  logic            iWbEn,
    input  logic [4:0]      iWbAddr,
    input  logic [XLEN-1:0] iWbData
);
    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2, holdRs1, holdRs2;
    logic [XLEN-1:0] rdA, rdB, rs1Val, rs2Val, immB;
    logic isShift, legal, regB, holdBReg, accept, stall, wbLive;
    bundle_t nxt, bun;
    bundleState_t state, stateNxt;

    assign opcode = iInstr[6:0];
    assign rd     = iInstr[11:7];
    assign f3     = iInstr[14:12];
    assign rs1    = iInstr[19:15];
    assign rs2    = iInstr[24:20];
    assign f7     = iInstr[31:25];

    reg_file uRegFile (
        .iClk    (iClk),
        .iRstN   (iRstN),
        .iWe     (iWbEn),
        .iWAddr  (iWbAddr),
        .iWData  (iWbData),
        .iRAddrA (rs1),
        .oRDataA (rdA),
        .iRAddrB (rs2),
        .oRDataB (rdB)
    );

    always_comb begin
        isShift = (f3 == F3_SLL) || (f3 == F3_SRLSRA);
        regB    = opcode == OPC_OP;
        legal   = regB ? (f7 == FUNCT7_BASE || (f7 == FUNCT7_ALT && (f3 == F3_ADDSUB || f3 == F3_SRLSRA)))
                : (opcode == OPC_OPIMM) ? (!isShift || f7 == FUNCT7_BASE || (f7 == FUNCT7_ALT && f3 == F3_SRLSRA))
                : 1'b0;
        rs1Val  = (wbLive && iWbAddr == rs1) ? iWbData : rdA;
        rs2Val  = (wbLive && iWbAddr == rs2) ? iWbData : rdB;
        immB    = isShift ? {27'b0, rs2} : {{20{iInstr[31]}}, iInstr[31:20]};
        nxt.dataA   = legal ? rs1Val : '0;
        nxt.dataB   = !legal ? '0 : regB ? rs2Val : immB;
        nxt.funct3  = legal ? f3 : '0;
        nxt.funct7  = (legal && (regB || isShift)) ? f7 : '0;
        nxt.rd      = legal ? rd : '0;
        nxt.illegal = !legal;
    end

    assign wbLive      = iWbEn && iWbAddr != '0;
    assign oOpValid    = state == FULL;
    assign oInstrReady = !oOpValid || iOpReady;
    assign accept      = iInstrValid && oInstrReady;
    assign stall       = oOpValid && !iOpReady;
    assign stateNxt    = (accept || stall) ? FULL : EMPTY;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) state <= EMPTY;
        else        state <= stateNxt;
    end

    // Illegal bundles keep holdRs1 = 0 and holdBReg = 0 so their zeroed operands are never refreshed
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            bun      <= '0;
            holdRs1  <= '0;
            holdRs2  <= '0;
            holdBReg <= 1'b0;
        end else if (accept) begin
            bun      <= nxt;
            holdRs1  <= legal ? rs1 : '0;
            holdRs2  <= rs2;
            holdBReg <= legal && regB;
        end else if (stall && wbLive) begin
            if (iWbAddr == holdRs1) bun.dataA <= iWbData;
            if (holdBReg && iWbAddr == holdRs2) bun.dataB <= iWbData;
        end
    end

    assign oDataA   = bun.dataA;
    assign oDataB   = bun.dataB;
    assign oFunct3  = bun.funct3;
    assign oFunct7  = bun.funct7;
    assign oRd      = bun.rd;
    assign oIllegal = bun.illegal;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed vectors with a scoreboard queue checked by an independent output monitor
module tb_alu_operand_stage;
    typedef logic [79:0] exp_t;

    logic iClk = 1'b0, iRstN = 1'b0, iInstrValid = 1'b0, iOpReady = 1'b1, iWbEn = 1'b0;
    logic [31:0] iInstr = '0, iWbData = '0;
    logic [4:0]  iWbAddr = '0;
    logic oInstrReady, oOpValid, oIllegal;
    logic [31:0] oDataA, oDataB;
    logic [2:0]  oFunct3;
    logic [6:0]  oFunct7;
    logic [4:0]  oRd;
    exp_t got;
    exp_t expQ[$];
    string nameQ[$];
    int vectors = 0, miscompares = 0;

    always #5 iClk = ~iClk;

    alu_operand_stage dut (
        .iClk        (iClk),
        .iRstN       (iRstN),
        .iInstrValid (iInstrValid),
        .iInstr      (iInstr),
        .oInstrReady (oInstrReady),
        .oOpValid    (oOpValid),
        .iOpReady    (iOpReady),
        .oDataA      (oDataA),
        .oDataB      (oDataB),
        .oFunct3     (oFunct3),
        .oFunct7     (oFunct7),
        .oRd         (oRd),
        .oIllegal    (oIllegal),
        .iWbEn       (iWbEn),
        .iWbAddr     (iWbAddr),
        .iWbData     (iWbData)
    );

    assign got = {oDataA, oDataB, oFunct3, oFunct7, oRd, oIllegal};

    function automatic exp_t mk(logic [31:0] a, logic [31:0] b, logic [2:0] f3, logic [6:0] f7, logic [4:0] rd, logic ill);
        return {a, b, f3, f7, rd, ill};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic step;
        @(posedge iClk);
        #1;
    endtask

    task automatic wb(logic [4:0] addr, logic [31:0] data);
        iWbEn = 1'b1; iWbAddr = addr; iWbData = data;
        step();
        iWbEn = 1'b0;
    endtask

    task automatic issue(string name, logic [31:0] instr, exp_t e);
        check({name, " ready"}, {31'b0, oInstrReady}, 32'd1);
        iInstrValid = 1'b1; iInstr = instr;
        expQ.push_back(e); nameQ.push_back(name);
        step();
        iInstrValid = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        string n;
        forever begin
            @(negedge iClk);
            if (iRstN && oOpValid && iOpReady) begin
                vectors++;
                if (expQ.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected bundle: got %h, expected none", got);
                end else begin
                    e = expQ.pop_front();
                    n = nameQ.pop_front();
                    if (got !== e) begin
                        miscompares++;
                        $display("FAIL %s: got A=%h B=%h f3=%b f7=%b rd=%0d ill=%b, expected A=%h B=%h f3=%b f7=%b rd=%0d ill=%b",
                                 n, oDataA, oDataB, oFunct3, oFunct7, oRd, oIllegal,
                                 e[79:48], e[47:16], e[15:13], e[12:6], e[5:1], e[0]);
                    end
                end
            end
        end
    end

    initial begin
        #12;
        check("reset valid", {31'b0, oOpValid}, 32'd0);
        check("reset ready", {31'b0, oInstrReady}, 32'd1);
        check("reset dataA", oDataA, 32'd0);
        check("reset dataB", oDataB, 32'd0);
        check("reset ctl", {16'b0, oFunct3, oFunct7, oRd, oIllegal}, 32'd0);
        @(posedge iClk); #1;
        iRstN = 1'b1;
        step();

        wb(5'd5, 32'h7);
        issue("addi x6,x5,-1", 32'hFFF28313, mk(32'h7, 32'hFFFF_FFFF, 3'b000, 7'h00, 5'd6, 1'b0));

        iWbEn = 1'b1; iWbAddr = 5'd2; iWbData = 32'h1234;
        issue("sub bypass", 32'h402081B3, mk(32'h0, 32'h1234, 3'b000, 7'h20, 5'd3, 1'b0));
        iWbEn = 1'b0;
        step();

        iOpReady = 1'b0;
        issue("or stalled refresh", 32'h0020E233, mk(32'hA5A5_A5A5, 32'h1234, 3'b110, 7'h00, 5'd4, 1'b0));
        iInstrValid = 1'b1; iInstr = 32'h002084B3;
        iWbEn = 1'b1; iWbAddr = 5'd1; iWbData = 32'hA5A5_A5A5;
        check("stall ready", {31'b0, oInstrReady}, 32'd0);
        step();
        iWbEn = 1'b0;
        check("stall refresh dataA", oDataA, 32'hA5A5_A5A5);
        check("stall held rd", {27'b0, oRd}, 32'd4);
        iOpReady = 1'b1;
        expQ.push_back(mk(32'hA5A5_A5A5, 32'h1234, 3'b000, 7'h00, 5'd9, 1'b0));
        nameQ.push_back("add after stall");
        step();
        iInstrValid = 1'b0;

        wb(5'd8, 32'h8000_0000);
        issue("srai x7,x8,3", 32'h40345393, mk(32'h8000_0000, 32'h3, 3'b101, 7'h20, 5'd7, 1'b0));
        issue("slli alt illegal", 32'h40341393, mk(32'h0, 32'h0, 3'b000, 7'h00, 5'd0, 1'b1));
        issue("sll alt illegal", 32'h402091B3, mk(32'h0, 32'h0, 3'b000, 7'h00, 5'd0, 1'b1));
        issue("addi f7 bits", 32'h40000513, mk(32'h0, 32'h400, 3'b000, 7'h00, 5'd10, 1'b0));

        wb(5'd0, 32'hFFFF_FFFF);
        iWbEn = 1'b1; iWbAddr = 5'd0; iWbData = 32'hFFFF_FFFF;
        issue("add x1,x0,x0", 32'h000000B3, mk(32'h0, 32'h0, 3'b000, 7'h00, 5'd1, 1'b0));
        iWbEn = 1'b0;
        issue("load opcode", 32'h0000A283, mk(32'h0, 32'h0, 3'b000, 7'h00, 5'd0, 1'b1));

        issue("b2b addi 1", 32'h00100593, mk(32'h0, 32'h1, 3'b000, 7'h00, 5'd11, 1'b0));
        issue("b2b addi 2", 32'h00200613, mk(32'h0, 32'h2, 3'b000, 7'h00, 5'd12, 1'b0));
        issue("b2b addi min", 32'h80000693, mk(32'h0, 32'hFFFF_F800, 3'b000, 7'h00, 5'd13, 1'b0));
        step();

        iOpReady = 1'b0;
        iInstrValid = 1'b1; iInstr = 32'hFFF28313;
        step();
        iInstrValid = 1'b0;
        check("held before reset", {31'b0, oOpValid}, 32'd1);
        #2 iRstN = 1'b0;
        #1;
        check("async reset valid", {31'b0, oOpValid}, 32'd0);
        check("async reset ready", {31'b0, oInstrReady}, 32'd1);
        @(posedge iClk); #1;
        iRstN = 1'b1;
        iOpReady = 1'b1;
        step();
        step();
        check("post reset idle", {31'b0, oOpValid}, 32'd0);
        issue("regs cleared", 32'h00228733, mk(32'h0, 32'h0, 3'b000, 7'h00, 5'd14, 1'b0));
        step();
        step();
        check("scoreboard drained", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
